// File: rtl/cordic_hyp_vector.sv
// Iterative hyperbolic CORDIC in vectoring mode (Q3.28).
// Drives y to zero: z -> z0 + atanh(y0/x0), x -> Kh*sqrt(x0^2 - y0^2).
module cordic_hyp_vector #(
    parameter int NITER = 24,
    parameter int FRAC  = 28
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] ix,
    input  logic signed [31:0] iy,
    input  logic signed [31:0] iz,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] ox,
    output logic signed [31:0] oy,
    output logic signed [31:0] oz,
    output logic               oerr,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising CLK edge where valid and ready are both 1;
    // in_ready is 1 only in IDLE, out_valid only in DONE, and DONE outputs are frozen.
    localparam int STEPS = NITER + 2;
    localparam logic signed [31:0] FOUR = 32'sd1 <<< (FRAC + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic signed [31:0] x, y, z;
    logic signed [31:0] x_n, y_n, z_n;
    logic signed [31:0] xs, ys, lut;
    logic signed [32:0] y_abs;
    logic [5:0]         step;
    logic [4:0]         sh;
    logic               rep;
    logic               err;
    logic               bad;

    // round(atanh(2^-i) * 2^28); beyond i=9 the cubic term is below half an LSB.
    function automatic logic signed [31:0] atanh_lut(input logic [4:0] i);
        case (i)
            5'd1:    atanh_lut = 32'sd147453245;
            5'd2:    atanh_lut = 32'sd68561855;
            5'd3:    atanh_lut = 32'sd33730852;
            5'd4:    atanh_lut = 32'sd16799113;
            5'd5:    atanh_lut = 32'sd8391340;
            5'd6:    atanh_lut = 32'sd4194645;
            5'd7:    atanh_lut = 32'sd2097195;
            5'd8:    atanh_lut = 32'sd1048581;
            5'd9:    atanh_lut = 32'sd524289;
            default: atanh_lut = (int'(i) > FRAC) ? 32'sd0 : (32'sd1 <<< (FRAC - int'(i)));
        endcase
    endfunction

    always_comb begin
        y_abs = y[31] ? -{y[31], y} : {y[31], y};
        bad   = (x <= 32'sd0) || (y_abs >= {x[31], x}) || (x >= FOUR);
        xs    = x >>> sh;
        ys    = y >>> sh;
        lut   = atanh_lut(sh);
        if (!y[31]) begin
            x_n = x - ys;
            y_n = y - xs;
            z_n = z + lut;
        end else begin
            x_n = x + ys;
            y_n = y + xs;
            z_n = z - lut;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = RUN;
            RUN: begin
                if (step == 6'd0 && bad) state_n = DONE;
                else if (step == 6'(STEPS - 1)) state_n = DONE;
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            err  <= 1'b0;
            step <= '0;
            sh   <= 5'd1;
            rep  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x    <= ix;
                        y    <= iy;
                        z    <= iz;
                        err  <= 1'b0;
                        step <= '0;
                        sh   <= 5'd1;
                        rep  <= 1'b0;
                    end
                end
                RUN: begin
                    // The first RUN cycle also screens the latched operands.
                    if (step == 6'd0 && bad) begin
                        x   <= '0;
                        y   <= '0;
                        z   <= '0;
                        err <= 1'b1;
                    end else begin
                        x    <= x_n;
                        y    <= y_n;
                        z    <= z_n;
                        step <= step + 6'd1;
                        if ((sh == 5'd4 || sh == 5'd13) && !rep) begin
                            rep <= 1'b1;
                        end else begin
                            sh  <= sh + 5'd1;
                            rep <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ox        = x;
    assign oy        = y;
    assign oz        = z;
    assign oerr      = err;
    assign dbg_state = state;

endmodule

// File: tb/tb_cordic_hyp_vector.sv
// Bench for cordic_hyp_vector: directed vectors plus log-path sweep, scoreboard-checked.
module tb_cordic_hyp_vector;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic signed [31:0] ix = '0, iy = '0, iz = '0;
    logic              in_ready, out_valid, oerr;
    logic signed [31:0] ox, oy, oz;
    logic [1:0]        dbg_state;

    cordic_hyp_vector dut (
        .CLK(clk), .RSTN(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .ix(ix), .iy(iy), .iz(iz),
        .out_valid(out_valid), .out_ready(out_ready),
        .ox(ox), .oy(oy), .oz(oz), .oerr(oerr),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam real SCALE = 268435456.0;
    localparam real KH    = 0.828159;

    typedef struct {
        bit err;
        int ez;
        int ztol;
        bit cx;
        int ex;
        int xtol;
        bit cy;
        int ytol;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void check(string name, bit ok, longint act, longint req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    function automatic void check_tol(string name, int act, int req, int tol);
        longint d = longint'(act) - longint'(req);
        check(name, (d <= tol) && (d >= -tol), act, req);
    endfunction

    function automatic int rnd(real r);
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    endfunction

    function automatic exp_t mk_ok(int ez, int ex, bit cy);
        exp_t e;
        e.err = 1'b0; e.ez = ez; e.ztol = 64; e.cx = 1'b1; e.ex = ex; e.xtol = 2048;
        e.cy = cy; e.ytol = 32; e.lat = 26; e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk_err();
        exp_t e;
        e.err = 1'b1; e.ez = 0; e.ztol = 0; e.cx = 1'b1; e.ex = 0; e.xtol = 0;
        e.cy = 1'b1; e.ytol = 0; e.lat = 1; e.acc = 0;
        return e;
    endfunction

    // driver: called just after a rising edge; returns one tick after the accept edge
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input exp_t e, output int acc);
        int guard = 0;
        in_valid = 1'b1; ix = x; iy = y; iz = z;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        acc = -1;
        if (!in_ready) begin
            check("accept_timeout", 1'b0, guard, 0);
        end else begin
            acc   = cyc + 1;
            e.acc = acc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    // monitor / scoreboard
    int   rise_cyc = 0;
    bit   ov_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rstn) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b0, oz, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("oerr", oerr == mon_e.err, oerr, mon_e.err);
                    check_tol("oz", oz, mon_e.ez, mon_e.ztol);
                    if (mon_e.cx) check_tol("ox", ox, mon_e.ex, mon_e.xtol);
                    if (mon_e.cy) check_tol("oy", oy, 0, mon_e.ytol);
                    check("latency", (rise_cyc - mon_e.acc) == mon_e.lat, rise_cyc - mon_e.acc, mon_e.lat);
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1);
    end

    initial begin
        int acc, prev_acc;
        logic signed [31:0] hx, hy, hz;
        logic he;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_oerr", oerr == 1'b0, oerr, 0);
        check("rst_outputs", (ox == 0) && (oy == 0) && (oz == 0), ox | oy | oz, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 0.5*ln(2) = 0.346574 -> 93032640
        send(32'h3000_0000, 32'h1000_0000, 32'h0, mk_ok(93032640, rnd(KH * $sqrt(8.0) * SCALE), 1'b0), acc);
        send(32'h1000_0000, 32'h0, 32'h0400_0000, mk_ok(67108864, rnd(KH * SCALE), 1'b1), acc);
        // z0 = 1/16, y0 negative: 2^24 - atanh(0.5)*2^28
        send(32'h2000_0000, 32'hF000_0000, 32'h0100_0000, mk_ok(-130676029, rnd(KH * $sqrt(3.0) * SCALE), 1'b0), acc);
        // x0 just below 4.0: atanh(0.5/4) = 0.125657 -> 33730852
        send(32'h3FFF_FFFF, 32'h0800_0000, 32'h0, mk_ok(33730852, rnd(KH * $sqrt(15.75) * SCALE), 1'b0), acc);
        // domain errors
        send(32'h1000_0000, 32'h1000_0000, 32'h0, mk_err(), acc);
        send(32'hF000_0000, 32'h0, 32'h0, mk_err(), acc);
        send(32'h4000_0000, 32'h0, 32'h0, mk_err(), acc);
        send(32'h1000_0000, 32'hF000_0000, 32'h0, mk_err(), acc);
        send(32'h0, 32'h0, 32'h0, mk_err(), acc);
        drain();

        // back-pressure hold in DONE; atanh(0.25) -> 68561855
        out_ready = 1'b0;
        send(32'h2000_0000, 32'h0800_0000, 32'h0, mk_ok(68561855, rnd(KH * $sqrt(3.75) * SCALE), 1'b0), acc);
        begin
            int guard = 0;
            while (!out_valid && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        check("hold_reached_done", out_valid == 1'b1, out_valid, 1);
        hx = ox; hy = oy; hz = oz; he = oerr;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            ix = $urandom_range(32'h0800_0000, 32'h3000_0000);
            iy = 32'h0;
            @(posedge clk); #1;
            check("hold_stable", (ox == hx) && (oy == hy) && (oz == hz) && (oerr == he) && out_valid,
                  oz, hz);
            check("hold_in_ready", in_ready == 1'b0, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", out_valid == 1'b0, out_valid, 0);
        check("release_in_ready", in_ready == 1'b1, in_ready, 1);
        drain();

        // reset mid-RUN drops the operation
        send(32'h3000_0000, 32'h1000_0000, 32'h0, mk_ok(93032640, rnd(KH * $sqrt(8.0) * SCALE), 1'b0), acc);
        repeat (9) @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        send(32'h1000_0000, 32'h0, 32'h0400_0000, mk_ok(67108864, rnd(KH * SCALE), 1'b1), acc);
        drain();

        // log path sweep, back-to-back: x0=(w+1)/2, y0=(w-1)/2 -> z = 0.5*ln(w)
        prev_acc = 0;
        for (int n = 0; n < 100; n++) begin
            real w, xr, yr;
            int  x0, y0;
            w  = real'($urandom_range(110, 3500)) / 1000.0;
            x0 = rnd((w + 1.0) / 2.0 * SCALE);
            y0 = rnd((w - 1.0) / 2.0 * SCALE);
            xr = real'(x0) / SCALE;
            yr = real'(y0) / SCALE;
            send(x0, y0, 32'h0,
                 mk_ok(rnd(0.5 * $ln((xr + yr) / (xr - yr)) * SCALE),
                       rnd(KH * $sqrt(xr * xr - yr * yr) * SCALE), 1'b0), acc);
            if (n > 0) check("throughput", (acc - prev_acc) == 28, acc - prev_acc, 28);
            prev_acc = acc;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
